// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the single-clock FIFO family.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEF_ADD  = 3;
    localparam int c_DEF_DATA = 8;

    // Read-mode selector values for the FWFT parameter
    localparam logic c_MODE_STD  = 1'b0;
    localparam logic c_MODE_FWFT = 1'b1;

    function automatic int depth(input int add);
        return 1 << add;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : 2^ADD x DATA register array, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int ADD  = c_DEF_ADD,
    parameter int DATA = c_DEF_DATA
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADD-1:0]  waddr,
    input  logic [DATA-1:0] wdata,
    input  logic [ADD-1:0]  raddr,
    output logic [DATA-1:0] rdata
);

    logic [DATA-1:0] r_mem [0:depth(ADD)-1];

    // Contents are deliberately left unreset; control logic never exposes stale words
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with count, threshold flags, sticky errors
//               and selectable standard / first-word-fall-through read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int ADD    = c_DEF_ADD,
    parameter int DATA   = c_DEF_DATA,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 1,
    parameter int FWFT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [DATA-1:0] wdata,
    input  logic            r_en,
    output logic [DATA-1:0] rdata,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [ADD:0]    count,
    output logic            overflow,
    output logic            underflow,
    input  logic            clr_err
);

    localparam logic [ADD:0] c_DEPTH = (ADD+1)'(depth(ADD));
    localparam logic [ADD:0] c_AF    = (ADD+1)'(AF_LVL);
    localparam logic [ADD:0] c_AE    = (ADD+1)'(AE_LVL);

    logic [ADD-1:0]  r_wptr;
    logic [ADD-1:0]  r_rptr;
    logic [ADD:0]    r_count;
    logic            r_overflow;
    logic            r_underflow;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [DATA-1:0] w_mem_rdata;

    // Flags decode from the registered count only, so they never glitch
    assign full         = (r_count == c_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = w_en && !full;
    assign w_rd_acc = r_en && !empty;

    fifo_mem #(
        .ADD  (ADD),
        .DATA (DATA)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_wptr),
        .wdata (wdata),
        .raddr (r_rptr),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A new error event in the same cycle as clr_err keeps the flag set
            if (w_en && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (r_en && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == int'(c_MODE_FWFT)) begin : g_fwft
            // Forced to zero while empty so reset and drained states show no old data
            assign rdata = empty ? '0 : w_mem_rdata;
        end else begin : g_std
            logic [DATA-1:0] r_rdata;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= w_mem_rdata;
                end
            end
            assign rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Self-checking bench for sync_fifo_flags, standard and FWFT
//               instances driven in parallel against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

    localparam int c_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] s_rdata, f_rdata;
    logic [3:0] s_count, f_count;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_uf;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_uf;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] q[$];
    logic       m_ov = 1'b0;
    logic       m_uf = 1'b0;
    logic [7:0] m_rd = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flags #(.ADD(3), .DATA(8), .AF_LVL(6), .AE_LVL(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .rdata(s_rdata),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ov), .underflow(s_uf), .clr_err(clr_err)
    );

    sync_fifo_flags #(.ADD(3), .DATA(8), .AF_LVL(6), .AE_LVL(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .rdata(f_rdata),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ov), .underflow(f_uf), .clr_err(clr_err)
    );

    // Drive one cycle of stimulus and advance the queue model by the FIFO rules
    task automatic tick(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit mfull, mempty;
        w_en = w; wdata = d; r_en = r; clr_err = c;
        @(posedge clk);
        mfull  = (q.size() == c_DEPTH);
        mempty = (q.size() == 0);
        if (r && !mempty) m_rd = q.pop_front();
        if (w && !mfull) q.push_back(d);
        if (w && mfull) m_ov = 1'b1; else if (c) m_ov = 1'b0;
        if (r && mempty) m_uf = 1'b1; else if (c) m_uf = 1'b0;
        #1;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    endtask

    function automatic logic [7:0] head();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b want 1100", {s_empty, s_ae, s_full, s_af}); end
        vectors++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
        vectors++; if (s_rdata !== 8'h00 || f_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h/%h want 00", s_rdata, f_rdata); end
        vectors++; if ({s_ov, s_uf, f_ov, f_uf} !== 4'b0000) begin errors++; $display("FAIL reset_err got %b want 0000", {s_ov, s_uf, f_ov, f_uf}); end
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin errors++; $display("FAIL idle got empty=%b count=%0d want 1/0", s_empty, s_count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            vectors++; if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d want %0d", s_count, i); end
            vectors++; if (s_ae !== (i <= 1) || s_af !== (i >= 6) || s_full !== (i == 8) || s_empty !== 1'b0)
                begin errors++; $display("FAIL fill_flags n=%0d got ae=%b af=%b full=%b empty=%b", i, s_ae, s_af, s_full, s_empty); end
            vectors++; if (f_rdata !== 8'h01) begin errors++; $display("FAIL fill_fwft_head got %h want 01", f_rdata); end
        end
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        vectors++; if (s_ov !== 1'b1 || f_ov !== 1'b1 || s_count !== 4'd8) begin errors++; $display("FAIL overflow got ov=%b count=%0d want 1/8", s_ov, s_count); end
    endtask

    task automatic test_drain();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (s_ov !== 1'b0) begin errors++; $display("FAIL clr_ov got %b want 0", s_ov); end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++; if (s_rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata got %h want %h", s_rdata, 8'(i)); end
            vectors++; if (f_rdata !== head()) begin errors++; $display("FAIL drain_fwft got %h want %h", f_rdata, head()); end
        end
        vectors++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin errors++; $display("FAIL drain_empty got %b want 1", s_empty); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (s_uf !== 1'b1 || s_rdata !== 8'h08) begin errors++; $display("FAIL underflow got uf=%b rdata=%h want 1/08", s_uf, s_rdata); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++; if (f_rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_fwft got %h want %h", f_rdata, 8'h10 + 8'(i)); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++; if (s_rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_rdata got %h want %h", s_rdata, 8'h10 + 8'(i)); end
        end
        vectors++; if (s_count !== 4'd0 || f_count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", s_count); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] first;
        first = 8'($urandom);
        tick(1'b1, first, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b1, 1'b0);
        vectors++; if (s_count !== 4'd7 || s_ov !== 1'b1 || s_rdata !== first) begin errors++; $display("FAIL full_rw got count=%0d ov=%b rdata=%h want 7/1/%h", s_count, s_ov, s_rdata, first); end
        for (int i = 0; i < 7; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h5A, 1'b1, 1'b0);
        vectors++; if (s_count !== 4'd1 || s_uf !== 1'b1 || f_rdata !== 8'h5A) begin errors++; $display("FAIL empty_rw got count=%0d uf=%b fr=%h want 1/1/5a", s_count, s_uf, f_rdata); end
        for (int i = 1; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (s_ov !== 1'b0 || s_uf !== 1'b0) begin errors++; $display("FAIL clr_both got %b%b want 00", s_ov, s_uf); end
        tick(1'b1, 8'h77, 1'b0, 1'b1);
        vectors++; if (s_ov !== 1'b1 || f_ov !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", s_ov); end
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b1, 1'b1);
        vectors++; if (s_count !== 4'd0 || s_ov !== 1'b0) begin errors++; $display("FAIL sim_end got count=%0d ov=%b want 0/0", s_count, s_ov); end
    endtask

    task automatic test_fwft_reset();
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        vectors++; if (f_empty !== 1'b0 || f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_show got empty=%b rdata=%h want 0/a5", f_empty, f_rdata); end
        for (int i = 0; i < 3; i++) tick(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        q.delete(); m_ov = 1'b0; m_uf = 1'b0; m_rd = 8'h00;
        vectors++; if ({f_empty, f_ae, f_full, f_af, f_ov, f_uf} !== 6'b110000 || f_count !== 4'd0 || f_rdata !== 8'h00)
            begin errors++; $display("FAIL async_rst_fwft got flags=%b count=%0d rdata=%h", {f_empty, f_ae, f_full, f_af, f_ov, f_uf}, f_count, f_rdata); end
        vectors++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100 || s_count !== 4'd0 || s_rdata !== 8'h00)
            begin errors++; $display("FAIL async_rst_std got flags=%b count=%0d rdata=%h", {s_empty, s_ae, s_full, s_af}, s_count, s_rdata); end
        #1 rst = 1'b1;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (f_rdata !== 8'h00 || s_rdata !== 8'h00 || f_uf !== 1'b1) begin errors++; $display("FAIL post_rst_read got %h/%h uf=%b want 00/00/1", f_rdata, s_rdata, f_uf); end
        tick(1'b1, 8'hC3, 1'b0, 1'b1);
        vectors++; if (f_rdata !== 8'hC3) begin errors++; $display("FAIL post_rst_new got %h want c3", f_rdata); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (s_rdata !== 8'hC3 || f_empty !== 1'b1) begin errors++; $display("FAIL post_rst_pop got %h empty=%b want c3/1", s_rdata, f_empty); end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
            n = q.size();
            vectors++;
            if (s_count !== 4'(n) || f_count !== 4'(n) || s_full !== (n == c_DEPTH) || s_empty !== (n == 0)
                || s_af !== (n >= 6) || s_ae !== (n <= 1) || s_ov !== m_ov || s_uf !== m_uf
                || f_ov !== m_ov || f_uf !== m_uf || s_rdata !== m_rd || f_rdata !== head())
                begin errors++; $display("FAIL random cyc=%0d count=%0d/%0d ov=%b/%b uf=%b/%b rd=%h/%h fr=%h/%h",
                    i, s_count, n, s_ov, m_ov, s_uf, m_uf, s_rdata, m_rd, f_rdata, head()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
